// File: rtl/bist_misr_checker_if.sv
// Bus between the BIST controller and the MISR checker. The controller drives
// the strobes and the CUT response, and the checker returns its signature and verdict.
interface bist_misr_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             init;
  logic             running;
  logic             finish;
  logic [WIDTH-1:0] cut_out;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] count;
  logic             result_valid;
  logic             pass;
  logic             protocol_err;

  modport master (
    output init, running, finish, cut_out,
    input  signature, count, result_valid, pass, protocol_err
  );

  modport slave (
    input  init, running, finish, cut_out,
    output signature, count, result_valid, pass, protocol_err
  );
endinterface

// File: rtl/bist_misr_checker.sv
// BIST response compactor. A MISR folds in the CUT output while the controller
// runs, and finish latches a held pass/fail verdict against the golden values.
module bist_misr_checker #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h002D,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter logic [WIDTH-1:0] GOLDEN = 16'hA5C3,
  parameter int               NCLOCK = 650,
  parameter int               CNT_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  bist_misr_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, COMPACT, RESULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] misr;
  logic [CNT_W-1:0] cnt;
  logic             rv;
  logic             pass_q;
  logic             err;

  logic [WIDTH-1:0] misr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             verdict;

  // Shift with polynomial feedback from the MSB, then fold in the response word.
  assign misr_nxt = {misr[WIDTH-2:0], 1'b0} ^ (misr[WIDTH-1] ? POLY : '0) ^ bus.cut_out;
  assign cnt_nxt  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign verdict  = (misr == GOLDEN) && (cnt == CNT_W'(NCLOCK)) && !err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      misr   <= SEED;
      cnt    <= '0;
      rv     <= 1'b0;
      pass_q <= 1'b0;
      err    <= 1'b0;
    end else if (bus.init) begin
      state  <= ARMED;
      misr   <= SEED;
      cnt    <= '0;
      rv     <= 1'b0;
      pass_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        ARMED, COMPACT: begin
          if (bus.finish) begin
            state  <= RESULT;
            rv     <= 1'b1;
            pass_q <= verdict;
          end else if (bus.running) begin
            state <= COMPACT;
            misr  <= misr_nxt;
            cnt   <= cnt_nxt;
          end
        end
        IDLE, RESULT: begin
          // Strobes outside a test are ignored apart from flagging the violation.
          if (bus.running || bus.finish) err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.signature    = misr;
  assign bus.count        = cnt;
  assign bus.result_valid = rv;
  assign bus.pass         = pass_q;
  assign bus.protocol_err = err;

endmodule
